// File: rtl/pdm_decimator_pkg.sv
// Shared constants and output-FSM state encoding for the PDM decimator.
package pdm_decimator_pkg;

    localparam int unsigned SAMPLE_W        = 9;
    localparam int unsigned WINDOW_LOG2_DEF = 8;
    localparam int unsigned CLK_DIV_DEF     = 25;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/pdm_decimator_clk_gen.sv
// Divides clk down to the microphone clock and flags the cycle in which it rises.
module pdm_clk_gen
    import pdm_decimator_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic pdm_clk,
    output logic strobe
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // strobe is registered alongside pdm_clk so both go high in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            pdm_clk <= 1'b0;
            strobe  <= 1'b0;
        end else begin
            strobe <= 1'b0;
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                pdm_clk <= ~pdm_clk;
                strobe  <= ~pdm_clk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pdm_decimator.sv
// PDM microphone front end: counts ones over a 2**WINDOW_LOG2-bit window and
// hands each count downstream through a valid/ack holding register.
module pdm_decimator
    import pdm_decimator_pkg::*;
#(
    parameter int unsigned CLK_DIV     = CLK_DIV_DEF,
    parameter int unsigned WINDOW_LOG2 = WINDOW_LOG2_DEF
) (
    input  logic                clk,
    input  logic                rst,
    output logic                pdm_clk,
    input  logic                pdm_data,
    output logic [SAMPLE_W-1:0] data_out,
    output logic                data_out_valid,
    input  logic                data_out_ack,
    output logic                overrun
);

    logic                   strobe;
    logic                   sync_meta;
    logic                   sync_bit;
    logic [WINDOW_LOG2-1:0] bit_cnt;
    logic [SAMPLE_W-1:0]    ones_cnt;
    logic [SAMPLE_W-1:0]    sample;
    logic                   complete;
    state_t                 state;

    pdm_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk     (clk),
        .rst     (rst),
        .pdm_clk (pdm_clk),
        .strobe  (strobe)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_bit  <= 1'b0;
        end else begin
            sync_meta <= pdm_data;
            sync_bit  <= sync_meta;
        end
    end

    // The completing bit is folded into sample, so the window total never
    // needs a separate add and the next window starts from zero cleanly.
    assign complete = strobe && (bit_cnt == '1);
    assign sample   = ones_cnt + SAMPLE_W'(sync_bit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= '0;
            ones_cnt <= '0;
        end else if (strobe) begin
            bit_cnt  <= bit_cnt + 1'b1;
            ones_cnt <= complete ? '0 : sample;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (complete) begin
                        data_out       <= sample;
                        data_out_valid <= 1'b1;
                        state          <= HOLD;
                    end
                end
                HOLD: begin
                    if (complete && data_out_ack) begin
                        data_out <= sample;
                    end else if (complete) begin
                        overrun <= 1'b1;
                    end else if (data_out_ack) begin
                        data_out_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state          <= IDLE;
                    data_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pdm_decimator.sv
// Directed bench for pdm_decimator: constant, alternating and handshake scenarios.
module tb_pdm_decimator;

    localparam int unsigned TIMEOUT = 3000;

    logic       clk = 1'b0;
    logic       rst;
    logic       pdm_clk;
    logic       pdm_data;
    logic [8:0] data_out;
    logic       data_out_valid;
    logic       data_out_ack;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int strobes;
    int mode;
    logic prev_pclk;

    always #5 clk = ~clk;

    pdm_decimator #(
        .CLK_DIV     (2),
        .WINDOW_LOG2 (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pdm_clk        (pdm_clk),
        .pdm_data       (pdm_data),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ack   (data_out_ack),
        .overrun        (overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clk cycle: sample at negedge, count pdm_clk rises, drive the next PDM bit.
    task automatic tick();
        @(negedge clk);
        if (pdm_clk && !prev_pclk) begin
            strobes++;
            if (mode == 2) pdm_data = ~pdm_data;
        end
        if (mode == 0) pdm_data = 1'b0;
        else if (mode == 1) pdm_data = 1'b1;
        prev_pclk = pdm_clk;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        strobes = 0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!data_out_valid && n < TIMEOUT) begin
            tick();
            n++;
        end
        check({tag, " valid timeout"}, 32'(data_out_valid), 32'd1);
    endtask

    task automatic wait_strobes(input string tag, input int target);
        int n = 0;
        while (strobes < target && n < TIMEOUT) begin
            tick();
            n++;
        end
        check({tag, " strobe timeout"}, 32'(strobes), 32'(target));
    endtask

    initial begin
        int ovr;
        int bad;
        int n;
        int reached;

        rst          = 1'b1;
        data_out_ack = 1'b0;
        pdm_data     = 1'b0;
        mode         = 1;
        strobes      = 0;
        prev_pclk    = 1'b0;
        repeat (2) tick();
        check("reset pdm_clk", 32'(pdm_clk), 32'd0);
        check("reset data_out", 32'(data_out), 32'd0);
        check("reset valid", 32'(data_out_valid), 32'd0);
        check("reset overrun", 32'(overrun), 32'd0);

        // all ones, ack tied high
        data_out_ack = 1'b1;
        mode = 1;
        do_reset();
        for (int w = 1; w <= 2; w++) begin
            wait_valid("ones");
            check("ones data", 32'(data_out), 32'd256);
            check("ones strobes", 32'(strobes), 32'(256 * w));
            tick();
            check("ones valid one cycle", 32'(data_out_valid), 32'd0);
        end

        // all zeros
        mode = 0;
        do_reset();
        wait_valid("zeros");
        check("zeros data", 32'(data_out), 32'd0);
        check("zeros strobes", 32'(strobes), 32'd256);
        tick();
        check("zeros valid one cycle", 32'(data_out_valid), 32'd0);

        // alternating bits
        mode = 2;
        do_reset();
        for (int w = 1; w <= 2; w++) begin
            wait_valid("toggle");
            check("toggle data", 32'(data_out), 32'd128);
            tick();
            check("toggle valid one cycle", 32'(data_out_valid), 32'd0);
        end

        // ack held low across a second completion
        data_out_ack = 1'b0;
        mode = 1;
        do_reset();
        wait_valid("hold");
        check("hold data", 32'(data_out), 32'd256);
        check("hold overrun idle", 32'(overrun), 32'd0);
        mode = 0;
        ovr = 0;
        bad = 0;
        n = 0;
        while (strobes < 512 && n < TIMEOUT) begin
            tick();
            n++;
            ovr += int'(overrun);
            if (data_out !== 9'd256 || data_out_valid !== 1'b1) bad++;
        end
        reached = strobes;
        repeat (4) begin
            tick();
            ovr += int'(overrun);
            if (data_out !== 9'd256 || data_out_valid !== 1'b1) bad++;
        end
        check("hold reach 512", 32'(reached), 32'd512);
        check("hold overrun pulses", 32'(ovr), 32'd1);
        check("hold stable cycles bad", 32'(bad), 32'd0);
        data_out_ack = 1'b1;
        tick();
        check("hold ack clears valid", 32'(data_out_valid), 32'd0);
        data_out_ack = 1'b0;

        // ack coincident with completion
        mode = 1;
        do_reset();
        wait_valid("coinc");
        check("coinc first data", 32'(data_out), 32'd256);
        mode = 0;
        ovr = 0;
        bad = 0;
        n = 0;
        while (strobes < 512 && n < TIMEOUT) begin
            tick();
            n++;
            ovr += int'(overrun);
            if (data_out_valid !== 1'b1) bad++;
        end
        check("coinc reach 512", 32'(strobes), 32'd512);
        data_out_ack = 1'b1;
        tick();
        ovr += int'(overrun);
        check("coinc new data", 32'(data_out), 32'd0);
        check("coinc valid kept", 32'(data_out_valid), 32'd1);
        data_out_ack = 1'b0;
        repeat (3) begin
            tick();
            ovr += int'(overrun);
            if (data_out_valid !== 1'b1) bad++;
        end
        check("coinc valid drops", 32'(bad), 32'd0);
        check("coinc overrun pulses", 32'(ovr), 32'd0);

        // reset while holding a sample
        rst = 1'b1;
        tick();
        check("rst hold valid", 32'(data_out_valid), 32'd0);
        check("rst hold overrun", 32'(overrun), 32'd0);
        rst = 1'b0;

        // reset in the middle of a window
        data_out_ack = 1'b1;
        mode = 1;
        do_reset();
        wait_strobes("mid", 100);
        rst = 1'b1;
        repeat (2) tick();
        check("mid rst pdm_clk", 32'(pdm_clk), 32'd0);
        check("mid rst data_out", 32'(data_out), 32'd0);
        check("mid rst valid", 32'(data_out_valid), 32'd0);
        check("mid rst overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        strobes = 0;
        wait_valid("mid");
        check("mid data", 32'(data_out), 32'd256);
        check("mid strobes", 32'(strobes), 32'd256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
